exec_unit_pipe: RTL and testbench
=================================

Name: exec_unit_pipe

Overview:
- Parametrised successor to the single-cycle integer execute stage of the Tomasulo core.
- Accepts one ready instruction per cycle from the reservation station and computes ALU, branch and jump results.
- Buffers results in an OUT_DEPTH-entry FIFO and drains them to the CDB under a valid/grant handshake.
- Supports flush on misprediction; optionally adds a multi-cycle MUL/MULH/MULHSU/MULHU path.

Parameters:
- XLEN, 32: data and address width.
- NICK_W, 4: ROB tag (nick) width.
- OUT_DEPTH, 4: result FIFO entries, power of two, >= 2.
- MUL_LAT, 3: multiplier latency in cycles, >= 2; used only with MUL_EN.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- rdy  in  1  global enable; when 0, all state holds.
- flush  in  1  misprediction clear.
- iss_valid  in  1  RS presents an instruction.
- iss_ready  out  1  unit accepts this cycle.
- iss_pc  in  XLEN  instruction PC.
- iss_op  in  OP_W  opcode (package enum).
- iss_imm  in  XLEN  sign-extended immediate.
- iss_nick  in  NICK_W  destination ROB tag.
- iss_rs1  in  XLEN  operand 1.
- iss_rs2  in  XLEN  operand 2.
- cdb_valid  out  1  FIFO head valid.
- cdb_grant  in  1  CDB arbiter accepts head.
- cdb_nick  out  NICK_W  head tag.
- cdb_dt  out  XLEN  head result.
- cdb_taken  out  1  head is a taken branch or jump.
- cdb_jpc  out  XLEN  head next-PC.

Behaviour:
- Reset: all FIFO pointers and the count are 0. cdb_valid=0, cdb_nick=0, cdb_dt=0, cdb_taken=0, cdb_jpc=0. The MUL FSM is IDLE.
- Priority: rst > flush > !rdy. While rdy=0, nothing is accepted or popped.
- Accept: an instruction is accepted when iss_valid && iss_ready.
- iss_ready condition: count < OUT_DEPTH and the MUL FSM is IDLE.
- iss_ready is registered-path only: it is computed from count and never depends combinationally on cdb_grant. A pop does not free a slot until the next cycle.
- Single-cycle ops: the result is pushed at the accepting clock edge. cdb_valid rises the cycle after acceptance if the FIFO was empty.
- Pop: occurs when cdb_valid && cdb_grant. A simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo OUT_DEPTH.
- Output ordering: cdb_* always reflect the head entry, which is FIFO order, i.e. issue order.
- Arithmetic and logic ops:
  - LUI: dt = imm.
  - AUIPC: dt = pc + imm.
  - ADD/ADDI, SUB, XOR, OR, AND and their immediate forms: standard semantics.
  - SLT/SLTI: signed compare; SLTU/SLTIU: unsigned compare; result zero-extended to XLEN.
  - Shifts use only the low log2(XLEN) bits of rs2/imm. SRA/SRAI are arithmetic (>>>).
  - For all non-control ops: taken=0, jpc = pc + 4.
- Branches (BEQ, BNE, BLT, BGE, BLTU, BGEU): dt = 0. If the condition holds, taken=1 and jpc = pc + imm; otherwise taken=0 and jpc = pc + 4.
- JAL: dt = pc + 4, taken=1, jpc = pc + imm.
- JALR: dt = pc + 4, taken=1, jpc = (rs1 + imm) with bit 0 cleared.
- Unknown op: the result is pushed with dt=0, taken=0, jpc=pc+4 so the ROB entry still retires.
- All adds are modulo 2^XLEN.
- Flush:
  - Synchronous: next cycle count=0 and cdb_valid=0.
  - The MUL FSM returns to IDLE with its result discarded.
  - An instruction presented in the flush cycle is dropped. iss_ready may be 1 during the flush cycle, but acceptance is ignored.

Optional Feature:
- Macro: EXEC_MUL_EN.
- Defined:
  - Ops MUL, MULH, MULHSU and MULHU are accepted.
  - FSM IDLE -> BUSY on accept, with the counter loaded to MUL_LAT-1 and operands latched.
  - BUSY counts down while rdy. At counter 0 it pushes the result and returns to IDLE.
  - iss_ready=0 while BUSY, so at most one push occurs per cycle.
  - The result reaches cdb_valid MUL_LAT cycles after acceptance (FIFO empty).
  - MUL gives the low XLEN bits; the H variants give the high XLEN bits of the 2*XLEN product with the stated signedness.
  - On accept, iss_ready also requires count < OUT_DEPTH.
- Undefined: MUL ops are treated as unknown ops; no FSM or multiplier logic is synthesised.

Decomposition:
- exec_pkg holds:
  - OP_W.
  - The opcode enum/defines, shared with decoder and RS.
  - Branch-taken encodings Jump/NotJump.
  - The result-entry struct {nick, dt, taken, jpc}.
- One sub-module: exec_result_fifo, a parametrised sync FIFO with flush, count and head outputs.
- ALU and branch evaluation stay combinational inside exec_unit_pipe.

Test Plan:
- Basic ALU: ADD rs1=0x7FFFFFFF, rs2=1, nick=3, grant=1 -> next cycle cdb_valid=1, nick=3, dt=0x80000000, taken=0, jpc=pc+4.
- Signed branch: BLT rs1=0xFFFFFFFF, rs2=1, pc=0x100, imm=0x20 -> taken=1, jpc=0x120. BLTU with the same operands -> taken=0, jpc=0x104.
- JALR: pc=0x40, rs1=0x1001, imm=2 -> dt=0x44, taken=1, jpc=0x1002.
- Backpressure: grant=0, issue 5 ADDs, OUT_DEPTH=4 -> iss_ready=0 after the 4th. Raise grant -> results drain in issue order with one cycle gap before the 5th is accepted.
- Flush: FIFO holds 3 entries, flush asserted with iss_valid=1 -> next cycle cdb_valid=0, count=0, and the new instruction never appears.
- EXEC_MUL_EN: MULHU 0xFFFFFFFF*0xFFFFFFFF, MUL_LAT=3 -> iss_ready=0 for 2 cycles, dt=0xFFFFFFFE at cycle 3. A flush mid-BUSY -> no result and the FSM is IDLE.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared execute-stage definitions: opcode encoding (common with decoder and RS),
// branch-taken encoding and the CDB result entry at the core's default widths.
package exec_pkg;

    localparam int unsigned OP_W       = 6;
    localparam int unsigned DEF_XLEN   = 32;
    localparam int unsigned DEF_NICK_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_LUI    = 6'd0,
        OP_AUIPC  = 6'd1,
        OP_JAL    = 6'd2,
        OP_JALR   = 6'd3,
        OP_BEQ    = 6'd4,
        OP_BNE    = 6'd5,
        OP_BLT    = 6'd6,
        OP_BGE    = 6'd7,
        OP_BLTU   = 6'd8,
        OP_BGEU   = 6'd9,
        OP_ADD    = 6'd10,
        OP_SUB    = 6'd11,
        OP_SLL    = 6'd12,
        OP_SLT    = 6'd13,
        OP_SLTU   = 6'd14,
        OP_XOR    = 6'd15,
        OP_SRL    = 6'd16,
        OP_SRA    = 6'd17,
        OP_OR     = 6'd18,
        OP_AND    = 6'd19,
        OP_ADDI   = 6'd20,
        OP_SLTI   = 6'd21,
        OP_SLTIU  = 6'd22,
        OP_XORI   = 6'd23,
        OP_ORI    = 6'd24,
        OP_ANDI   = 6'd25,
        OP_SLLI   = 6'd26,
        OP_SRLI   = 6'd27,
        OP_SRAI   = 6'd28,
        OP_MUL    = 6'd29,
        OP_MULH   = 6'd30,
        OP_MULHSU = 6'd31,
        OP_MULHU  = 6'd32
    } op_e;

    typedef enum logic {
        NOT_JUMP = 1'b0,
        JUMP     = 1'b1
    } taken_e;

    typedef struct packed {
        logic [DEF_NICK_W-1:0] nick;
        logic [DEF_XLEN-1:0]   dt;
        logic                  taken;
        logic [DEF_XLEN-1:0]   jpc;
    } res_entry_t;

    function automatic logic is_mul(input op_e op);
        return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);
    endfunction

endpackage

// File: rtl/exec_result_fifo.sv
// Result buffer between the execute stage and the CDB: sync FIFO with flush,
// occupancy count and a head view that is valid whenever the count is nonzero.
module exec_result_fifo
    import exec_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type         T     = res_entry_t
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         flush,
    input  logic                         push,
    input  T                             push_data,
    input  logic                         pop,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         head_valid,
    output T                             head_data
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    T                 mem_q [DEPTH];
    T                 mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        count_d = count_q;
        push_ok = push && (count_q < CNT_W'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        if (flush) begin
            wr_d    = '0;
            rd_d    = '0;
            count_d = '0;
        end else if (en) begin
            if (push_ok) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (pop_ok) begin
                rd_d = rd_q + PTR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                count_d = count_q + CNT_W'(1);
            end else if (!push_ok && pop_ok) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q   <= '{default: '0};
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign count      = count_q;
    assign head_valid = (count_q != '0);
    assign head_data  = mem_q[rd_q];

endmodule

// File: rtl/exec_unit_pipe.sv
// Integer execute stage: single-cycle ALU/branch/jump evaluation feeding a result
// FIFO drained to the CDB. Define EXEC_MUL_EN to add the multi-cycle MUL path.
module exec_unit_pipe
    import exec_pkg::*;
#(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NICK_W    = 4,
    parameter int unsigned OUT_DEPTH = 4,
    parameter int unsigned MUL_LAT   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              flush,
    input  logic              iss_valid,
    output logic              iss_ready,
    input  logic [XLEN-1:0]   iss_pc,
    input  logic [OP_W-1:0]   iss_op,
    input  logic [XLEN-1:0]   iss_imm,
    input  logic [NICK_W-1:0] iss_nick,
    input  logic [XLEN-1:0]   iss_rs1,
    input  logic [XLEN-1:0]   iss_rs2,
    output logic              cdb_valid,
    input  logic              cdb_grant,
    output logic [NICK_W-1:0] cdb_nick,
    output logic [XLEN-1:0]   cdb_dt,
    output logic              cdb_taken,
    output logic [XLEN-1:0]   cdb_jpc
);

    localparam int unsigned SH_W  = $clog2(XLEN);
    localparam int unsigned CNT_W = $clog2(OUT_DEPTH + 1);

    typedef struct packed {
        logic [NICK_W-1:0] nick;
        logic [XLEN-1:0]   dt;
        logic              taken;
        logic [XLEN-1:0]   jpc;
    } entry_t;

    if ((OUT_DEPTH < 2) || ((OUT_DEPTH & (OUT_DEPTH - 1)) != 0) || (MUL_LAT < 2)) begin : g_bad_param
        $error("exec_unit_pipe: OUT_DEPTH must be a power of two >= 2 and MUL_LAT >= 2");
    end

    op_e              op;
    logic [XLEN-1:0]  pc4;
    logic [XLEN-1:0]  alu_dt;
    logic             alu_taken;
    logic [XLEN-1:0]  alu_jpc;
    logic             is_br;
    logic             br_cond;
    entry_t           alu_entry;
    logic             accept;
    logic             mul_idle;
    logic             fifo_push;
    entry_t           fifo_din;
    entry_t           head;
    logic [CNT_W-1:0] fifo_count;

    // Single-cycle ALU, branch and jump evaluation.
    always_comb begin
        op        = op_e'(iss_op);
        pc4       = iss_pc + XLEN'(4);
        alu_dt    = '0;
        alu_taken = NOT_JUMP;
        alu_jpc   = pc4;
        is_br     = 1'b0;
        br_cond   = 1'b0;
        case (op)
            OP_LUI:   alu_dt = iss_imm;
            OP_AUIPC: alu_dt = iss_pc + iss_imm;
            OP_ADD:   alu_dt = iss_rs1 + iss_rs2;
            OP_ADDI:  alu_dt = iss_rs1 + iss_imm;
            OP_SUB:   alu_dt = iss_rs1 - iss_rs2;
            OP_XOR:   alu_dt = iss_rs1 ^ iss_rs2;
            OP_XORI:  alu_dt = iss_rs1 ^ iss_imm;
            OP_OR:    alu_dt = iss_rs1 | iss_rs2;
            OP_ORI:   alu_dt = iss_rs1 | iss_imm;
            OP_AND:   alu_dt = iss_rs1 & iss_rs2;
            OP_ANDI:  alu_dt = iss_rs1 & iss_imm;
            OP_SLT:   alu_dt = XLEN'($signed(iss_rs1) < $signed(iss_rs2));
            OP_SLTI:  alu_dt = XLEN'($signed(iss_rs1) < $signed(iss_imm));
            OP_SLTU:  alu_dt = XLEN'(iss_rs1 < iss_rs2);
            OP_SLTIU: alu_dt = XLEN'(iss_rs1 < iss_imm);
            OP_SLL:   alu_dt = iss_rs1 << iss_rs2[SH_W-1:0];
            OP_SLLI:  alu_dt = iss_rs1 << iss_imm[SH_W-1:0];
            OP_SRL:   alu_dt = iss_rs1 >> iss_rs2[SH_W-1:0];
            OP_SRLI:  alu_dt = iss_rs1 >> iss_imm[SH_W-1:0];
            OP_SRA:   alu_dt = XLEN'($signed(iss_rs1) >>> iss_rs2[SH_W-1:0]);
            OP_SRAI:  alu_dt = XLEN'($signed(iss_rs1) >>> iss_imm[SH_W-1:0]);
            OP_BEQ:   begin is_br = 1'b1; br_cond = (iss_rs1 == iss_rs2); end
            OP_BNE:   begin is_br = 1'b1; br_cond = (iss_rs1 != iss_rs2); end
            OP_BLT:   begin is_br = 1'b1; br_cond = ($signed(iss_rs1) < $signed(iss_rs2)); end
            OP_BGE:   begin is_br = 1'b1; br_cond = ($signed(iss_rs1) >= $signed(iss_rs2)); end
            OP_BLTU:  begin is_br = 1'b1; br_cond = (iss_rs1 < iss_rs2); end
            OP_BGEU:  begin is_br = 1'b1; br_cond = (iss_rs1 >= iss_rs2); end
            OP_JAL: begin
                alu_dt    = pc4;
                alu_taken = JUMP;
                alu_jpc   = iss_pc + iss_imm;
            end
            OP_JALR: begin
                alu_dt    = pc4;
                alu_taken = JUMP;
                alu_jpc   = (iss_rs1 + iss_imm) & ~XLEN'(1);
            end
            default: ;
        endcase
        if (is_br && br_cond) begin
            alu_taken = JUMP;
            alu_jpc   = iss_pc + iss_imm;
        end
        alu_entry = '{nick: iss_nick, dt: alu_dt, taken: alu_taken, jpc: alu_jpc};
    end

    // Ready is a function of registered state only, so a pop frees a slot one cycle later.
    assign iss_ready = (fifo_count < CNT_W'(OUT_DEPTH)) && mul_idle;
    assign accept    = iss_valid && iss_ready && rdy && !flush;

`ifdef EXEC_MUL_EN
    localparam int unsigned MCNT_W = $clog2(MUL_LAT);

    typedef enum logic {
        MUL_IDLE = 1'b0,
        MUL_BUSY = 1'b1
    } mul_state_e;

    mul_state_e        mul_state_q, mul_state_d;
    logic [MCNT_W-1:0] mul_cnt_q, mul_cnt_d;
    logic [XLEN-1:0]   mul_a_q, mul_a_d;
    logic [XLEN-1:0]   mul_b_q, mul_b_d;
    logic [XLEN-1:0]   mul_pc_q, mul_pc_d;
    op_e               mul_op_q, mul_op_d;
    logic [NICK_W-1:0] mul_nick_q, mul_nick_d;
    logic              mul_done;
    logic              a_sgn;
    logic              b_sgn;
    logic [2*XLEN-1:0] mul_ax;
    logic [2*XLEN-1:0] mul_bx;
    logic [2*XLEN-1:0] mul_prod;
    entry_t            mul_entry;

    // Latency counter: loaded with MUL_LAT-1, result pushed when it counts down to 0.
    always_comb begin
        mul_state_d = mul_state_q;
        mul_cnt_d   = mul_cnt_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_pc_d    = mul_pc_q;
        mul_op_d    = mul_op_q;
        mul_nick_d  = mul_nick_q;
        mul_done    = 1'b0;
        if (flush) begin
            mul_state_d = MUL_IDLE;
        end else if (rdy) begin
            case (mul_state_q)
                MUL_IDLE: begin
                    if (accept && is_mul(op)) begin
                        mul_state_d = MUL_BUSY;
                        mul_cnt_d   = MCNT_W'(MUL_LAT - 1);
                        mul_a_d     = iss_rs1;
                        mul_b_d     = iss_rs2;
                        mul_pc_d    = iss_pc;
                        mul_op_d    = op;
                        mul_nick_d  = iss_nick;
                    end
                end
                MUL_BUSY: begin
                    mul_cnt_d = mul_cnt_q - MCNT_W'(1);
                    if (mul_cnt_q == MCNT_W'(1)) begin
                        mul_done    = 1'b1;
                        mul_state_d = MUL_IDLE;
                    end
                end
                default: mul_state_d = MUL_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state_q <= MUL_IDLE;
            mul_cnt_q   <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            mul_pc_q    <= '0;
            mul_op_q    <= OP_MUL;
            mul_nick_q  <= '0;
        end else begin
            mul_state_q <= mul_state_d;
            mul_cnt_q   <= mul_cnt_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            mul_pc_q    <= mul_pc_d;
            mul_op_q    <= mul_op_d;
            mul_nick_q  <= mul_nick_d;
        end
    end

    // Sign-extend to 2*XLEN so one unsigned multiply covers all signedness variants.
    always_comb begin
        a_sgn     = (mul_op_q == OP_MULH) || (mul_op_q == OP_MULHSU);
        b_sgn     = (mul_op_q == OP_MULH);
        mul_ax    = {{XLEN{a_sgn & mul_a_q[XLEN-1]}}, mul_a_q};
        mul_bx    = {{XLEN{b_sgn & mul_b_q[XLEN-1]}}, mul_b_q};
        mul_prod  = mul_ax * mul_bx;
        mul_entry = '{nick:  mul_nick_q,
                      dt:    (mul_op_q == OP_MUL) ? mul_prod[XLEN-1:0] : mul_prod[2*XLEN-1:XLEN],
                      taken: NOT_JUMP,
                      jpc:   mul_pc_q + XLEN'(4)};
    end

    assign mul_idle  = (mul_state_q == MUL_IDLE);
    assign fifo_push = (accept && !is_mul(op)) || mul_done;
    assign fifo_din  = mul_done ? mul_entry : alu_entry;
`else
    assign mul_idle  = 1'b1;
    assign fifo_push = accept;
    assign fifo_din  = alu_entry;
`endif

    exec_result_fifo #(
        .DEPTH (OUT_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .en         (rdy),
        .flush      (flush),
        .push       (fifo_push),
        .push_data  (fifo_din),
        .pop        (cdb_grant),
        .count      (fifo_count),
        .head_valid (cdb_valid),
        .head_data  (head)
    );

    assign cdb_nick  = head.nick;
    assign cdb_dt    = head.dt;
    assign cdb_taken = head.taken;
    assign cdb_jpc   = head.jpc;

endmodule

// File: tb/tb_exec_unit_pipe.sv
// Directed bench for exec_unit_pipe; the MUL scenario is built when EXEC_MUL_EN is defined.
module tb_exec_unit_pipe;
    import exec_pkg::*;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NICK_W = 4;

    logic              clk;
    logic              rst;
    logic              rdy;
    logic              flush;
    logic              iss_valid;
    logic              iss_ready;
    logic [XLEN-1:0]   iss_pc;
    logic [OP_W-1:0]   iss_op;
    logic [XLEN-1:0]   iss_imm;
    logic [NICK_W-1:0] iss_nick;
    logic [XLEN-1:0]   iss_rs1;
    logic [XLEN-1:0]   iss_rs2;
    logic              cdb_valid;
    logic              cdb_grant;
    logic [NICK_W-1:0] cdb_nick;
    logic [XLEN-1:0]   cdb_dt;
    logic              cdb_taken;
    logic [XLEN-1:0]   cdb_jpc;

    int total;
    int bad;

    exec_unit_pipe #(
        .XLEN      (XLEN),
        .NICK_W    (NICK_W),
        .OUT_DEPTH (4),
        .MUL_LAT   (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rdy       (rdy),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_ready (iss_ready),
        .iss_pc    (iss_pc),
        .iss_op    (iss_op),
        .iss_imm   (iss_imm),
        .iss_nick  (iss_nick),
        .iss_rs1   (iss_rs1),
        .iss_rs2   (iss_rs2),
        .cdb_valid (cdb_valid),
        .cdb_grant (cdb_grant),
        .cdb_nick  (cdb_nick),
        .cdb_dt    (cdb_dt),
        .cdb_taken (cdb_taken),
        .cdb_jpc   (cdb_jpc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic [OP_W-1:0] op, input logic [31:0] pc, input logic [31:0] imm,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [3:0] nick);
        iss_valid = 1'b1;
        iss_op    = op;
        iss_pc    = pc;
        iss_imm   = imm;
        iss_rs1   = rs1;
        iss_rs2   = rs2;
        iss_nick  = nick;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy = 1'b1; flush = 1'b0; cdb_grant = 1'b0;
        iss_valid = 1'b0; iss_op = '0; iss_pc = '0; iss_imm = '0;
        iss_nick = '0; iss_rs1 = '0; iss_rs2 = '0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b0 || cdb_nick !== 4'h0 || cdb_dt !== 32'h0 || cdb_taken !== 1'b0 ||
            cdb_jpc !== 32'h0 || iss_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset: got v=%b nick=%h dt=%h taken=%b jpc=%h ready=%b, want all 0 and ready=1",
                     cdb_valid, cdb_nick, cdb_dt, cdb_taken, cdb_jpc, iss_ready);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_alu();
        logic [OP_W-1:0] ops [12];
        logic [31:0]     a   [12];
        logic [31:0]     b   [12];
        logic [31:0]     imm [12];
        logic [31:0]     exp [12];
        logic [31:0]     pc;
        logic [3:0]      nick;
        ops = '{OP_ADD, OP_SUB, OP_SRA, OP_SLT, OP_SLTU, OP_XORI, OP_SLLI, OP_LUI,
                OP_AUIPC, 6'h3F, OP_SRLI, OP_ORI};
        a   = '{32'h7FFFFFFF, 32'h5, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hF0F0F0F0,
                32'h1, 32'h0, 32'h0, 32'h1234, 32'h80000000, 32'h0F};
        b   = '{32'h1, 32'h7, 32'h24, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0, 32'h0, 32'h5678,
                32'h0, 32'h0};
        imm = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h21, 32'h12345000,
                32'h10, 32'h99, 32'h3F, 32'hF0};
        exp = '{32'h80000000, 32'hFFFFFFFE, 32'hF8000000, 32'h1, 32'h0, 32'h0F0F0F0F,
                32'h2, 32'h12345000, 32'h1030, 32'h0, 32'h1, 32'hFF};
        cdb_grant = 1'b1;
        for (int i = 0; i < 12; i++) begin
            pc   = 32'h1000 + 32'(i * 4);
            nick = 4'(i + 3);
            drive(ops[i], pc, imm[i], a[i], b[i], nick);
            @(negedge clk);
            total++;
            if (cdb_valid !== 1'b1 || cdb_nick !== nick || cdb_dt !== exp[i] ||
                cdb_taken !== 1'b0 || cdb_jpc !== pc + 32'h4) begin
                bad++;
                $display("FAIL alu[%0d]: got v=%b nick=%h dt=%h taken=%b jpc=%h, want v=1 nick=%h dt=%h taken=0 jpc=%h",
                         i, cdb_valid, cdb_nick, cdb_dt, cdb_taken, cdb_jpc, nick, exp[i], pc + 32'h4);
            end
        end
        iss_valid = 1'b0;
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL alu_drain: got v=%b want v=0", cdb_valid);
        end
    endtask

    task automatic test_control();
        logic [OP_W-1:0] ops [8];
        logic [31:0]     pc  [8];
        logic [31:0]     imm [8];
        logic [31:0]     a   [8];
        logic [31:0]     b   [8];
        logic [31:0]     edt [8];
        logic            etk [8];
        logic [31:0]     ejp [8];
        ops = '{OP_BLT, OP_BLTU, OP_BEQ, OP_BNE, OP_BGE, OP_BGEU, OP_JAL, OP_JALR};
        pc  = '{32'h100, 32'h100, 32'h200, 32'h200, 32'h300, 32'h300, 32'h400, 32'h40};
        imm = '{32'h20, 32'h20, 32'hFFFFFFF0, 32'hFFFFFFF0, 32'h8, 32'h8, 32'h100, 32'h2};
        a   = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h5, 32'h5, 32'h1, 32'h1, 32'h0, 32'h1001};
        b   = '{32'h1, 32'h1, 32'h5, 32'h5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'h0};
        edt = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h404, 32'h44};
        etk = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        ejp = '{32'h120, 32'h104, 32'h1F0, 32'h204, 32'h308, 32'h304, 32'h500, 32'h1002};
        cdb_grant = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(ops[i], pc[i], imm[i], a[i], b[i], 4'(i));
            @(negedge clk);
            total++;
            if (cdb_valid !== 1'b1 || cdb_nick !== 4'(i) || cdb_dt !== edt[i] ||
                cdb_taken !== etk[i] || cdb_jpc !== ejp[i]) begin
                bad++;
                $display("FAIL control[%0d]: got v=%b nick=%h dt=%h taken=%b jpc=%h, want v=1 nick=%h dt=%h taken=%b jpc=%h",
                         i, cdb_valid, cdb_nick, cdb_dt, cdb_taken, cdb_jpc, 4'(i), edt[i], etk[i], ejp[i]);
            end
        end
        iss_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        cdb_grant = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(OP_ADD, 32'h2000, 32'h0, 32'(k * 16), 32'h1, 4'(k));
            total++;
            if (iss_ready !== 1'b1) begin
                bad++;
                $display("FAIL bp_ready_fill[%0d]: got ready=%b want 1", k, iss_ready);
            end
            @(negedge clk);
        end
        drive(OP_ADD, 32'h2000, 32'h0, 32'h40, 32'h1, 4'd4);
        total++;
        if (iss_ready !== 1'b0 || cdb_valid !== 1'b1 || cdb_nick !== 4'd0) begin
            bad++;
            $display("FAIL bp_full: got ready=%b v=%b nick=%h, want ready=0 v=1 nick=0",
                     iss_ready, cdb_valid, cdb_nick);
        end
        cdb_grant = 1'b1;
        #1;
        total++;
        if (iss_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_grant_comb: got ready=%b want 0", iss_ready);
        end
        @(negedge clk);
        total++;
        if (iss_ready !== 1'b1 || cdb_nick !== 4'd1) begin
            bad++;
            $display("FAIL bp_slot_free: got ready=%b nick=%h, want ready=1 nick=1", iss_ready, cdb_nick);
        end
        @(negedge clk);
        iss_valid = 1'b0;
        for (int k = 2; k < 5; k++) begin
            total++;
            if (cdb_valid !== 1'b1 || cdb_nick !== 4'(k) || cdb_dt !== 32'(k * 16 + 1)) begin
                bad++;
                $display("FAIL bp_order[%0d]: got v=%b nick=%h dt=%h, want v=1 nick=%h dt=%h",
                         k, cdb_valid, cdb_nick, cdb_dt, 4'(k), 32'(k * 16 + 1));
            end
            @(negedge clk);
        end
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL bp_empty: got v=%b want 0", cdb_valid);
        end
    endtask

    task automatic test_flush();
        cdb_grant = 1'b0;
        for (int k = 5; k < 8; k++) begin
            drive(OP_ADD, 32'h3000, 32'h0, 32'(k), 32'h0, 4'(k));
            @(negedge clk);
        end
        drive(OP_ADD, 32'h3000, 32'h0, 32'h9, 32'h0, 4'd9);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        iss_valid = 1'b0;
        total++;
        if (cdb_valid !== 1'b0 || iss_ready !== 1'b1) begin
            bad++;
            $display("FAIL flush_clear: got v=%b ready=%b, want v=0 ready=1", cdb_valid, iss_ready);
        end
        cdb_grant = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (cdb_valid !== 1'b0) begin
                bad++;
                $display("FAIL flush_dropped[%0d]: got v=%b nick=%h, want v=0", c, cdb_valid, cdb_nick);
            end
        end
        drive(OP_ADD, 32'h3100, 32'h0, 32'h10, 32'h20, 4'hA);
        @(negedge clk);
        iss_valid = 1'b0;
        total++;
        if (cdb_valid !== 1'b1 || cdb_nick !== 4'hA || cdb_dt !== 32'h30) begin
            bad++;
            $display("FAIL flush_resume: got v=%b nick=%h dt=%h, want v=1 nick=a dt=30",
                     cdb_valid, cdb_nick, cdb_dt);
        end
        @(negedge clk);
    endtask

    task automatic test_rdy_hold();
        cdb_grant = 1'b1;
        rdy = 1'b0;
        drive(OP_ADD, 32'h4000, 32'h0, 32'h1, 32'h1, 4'd2);
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL rdy_no_accept: got v=%b want 0", cdb_valid);
        end
        rdy = 1'b1;
        @(negedge clk);
        iss_valid = 1'b0;
        rdy = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b1 || cdb_nick !== 4'd2 || cdb_dt !== 32'h2) begin
            bad++;
            $display("FAIL rdy_hold: got v=%b nick=%h dt=%h, want v=1 nick=2 dt=2", cdb_valid, cdb_nick, cdb_dt);
        end
        rdy = 1'b1;
        @(negedge clk);
        total++;
        if (cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL rdy_pop: got v=%b want 0", cdb_valid);
        end
    endtask

`ifdef EXEC_MUL_EN
    task automatic test_mul();
        logic [OP_W-1:0] ops [5];
        logic [31:0]     a   [5];
        logic [31:0]     b   [5];
        logic [31:0]     exp [5];
        logic [31:0]     pc;
        ops = '{OP_MULHU, OP_MUL, OP_MULH, OP_MULHSU, OP_MULH};
        a   = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF};
        b   = '{32'hFFFFFFFF, 32'h7, 32'h7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        exp = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0};
        cdb_grant = 1'b1;
        for (int i = 0; i < 5; i++) begin
            pc = 32'h80 + 32'(i * 4);
            drive(ops[i], pc, 32'h0, a[i], b[i], 4'(i));
            @(negedge clk);
            iss_valid = 1'b0;
            for (int c = 1; c < 3; c++) begin
                total++;
                if (iss_ready !== 1'b0 || cdb_valid !== 1'b0) begin
                    bad++;
                    $display("FAIL mul_busy[%0d] cycle %0d: got ready=%b v=%b, want ready=0 v=0",
                             i, c, iss_ready, cdb_valid);
                end
                @(negedge clk);
            end
            total++;
            if (cdb_valid !== 1'b1 || cdb_nick !== 4'(i) || cdb_dt !== exp[i] || cdb_taken !== 1'b0 ||
                cdb_jpc !== pc + 32'h4 || iss_ready !== 1'b1) begin
                bad++;
                $display("FAIL mul_result[%0d]: got v=%b nick=%h dt=%h taken=%b jpc=%h ready=%b, want v=1 nick=%h dt=%h taken=0 jpc=%h ready=1",
                         i, cdb_valid, cdb_nick, cdb_dt, cdb_taken, cdb_jpc, iss_ready, 4'(i), exp[i], pc + 32'h4);
            end
            @(negedge clk);
        end
        drive(OP_MUL, 32'h90, 32'h0, 32'h3, 32'h3, 4'd7);
        @(negedge clk);
        iss_valid = 1'b0;
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        total++;
        if (iss_ready !== 1'b1 || cdb_valid !== 1'b0) begin
            bad++;
            $display("FAIL mul_flush_idle: got ready=%b v=%b, want ready=1 v=0", iss_ready, cdb_valid);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            total++;
            if (cdb_valid !== 1'b0) begin
                bad++;
                $display("FAIL mul_flush_discard[%0d]: got v=%b dt=%h, want v=0", c, cdb_valid, cdb_dt);
            end
        end
    endtask
`else
    task automatic test_mul();
        cdb_grant = 1'b1;
        drive(OP_MUL, 32'h90, 32'h0, 32'h3, 32'h3, 4'd7);
        @(negedge clk);
        iss_valid = 1'b0;
        total++;
        if (cdb_valid !== 1'b1 || cdb_nick !== 4'd7 || cdb_dt !== 32'h0 || cdb_taken !== 1'b0 ||
            cdb_jpc !== 32'h94) begin
            bad++;
            $display("FAIL mul_as_unknown: got v=%b nick=%h dt=%h taken=%b jpc=%h, want v=1 nick=7 dt=0 taken=0 jpc=94",
                     cdb_valid, cdb_nick, cdb_dt, cdb_taken, cdb_jpc);
        end
        @(negedge clk);
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_alu();
        test_control();
        test_backpressure();
        test_flush();
        test_rdy_hold();
        test_mul();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
